// File: rtl/regfile_2r1w.sv
// regfile_2r1w -- parametrised 2-read / 1-write register file for the CPU datapath.
//
// Purpose:
//   NREGS = 2**ADDR_W registers of WIDTH bits. Two registered read ports with valid
//   flags, a write port with write-to-read bypass, and a per-register busy bit that
//   decode sets on issue and writeback clears when the result lands.
//
// Ports:
//   CLK                     clock, all state changes on the rising edge
//   RST                     synchronous reset, active-high
//   wen / waddr / wdata     write port (writeback)
//   ren_a / raddr_a         read request, port A
//   rdata_a                 registered read data, port A
//   rvalid_a                rdata_a holds the result of a read issued last cycle
//   rstale_a                the register read on port A had a result pending
//   ren_b ... rstale_b      same as port A, port B
//   issue / issue_sel       mark register issue_sel busy
//   busy                    busy vector, bit i = register i
//   dbg_sel / dbg_q         combinational view of stored register dbg_sel (no bypass)
//
// Handshake: a read is requested by holding ren_x high across one rising edge;
// the data appears on rdata_x with rvalid_x high for exactly the following cycle.
// There is no back-pressure; every request is accepted.
//
// Configuration macro:
//   ZERO_REG_EN  when defined, register 0 reads as zero, ignores writes and
//                never becomes busy.
module regfile_2r1w #(
   parameter int               WIDTH     = 16,
   parameter int               ADDR_W    = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    wen,
   input  logic [ADDR_W-1:0]       waddr,
   input  logic [WIDTH-1:0]        wdata,
   input  logic                    ren_a,
   input  logic [ADDR_W-1:0]       raddr_a,
   output logic [WIDTH-1:0]        rdata_a,
   output logic                    rvalid_a,
   output logic                    rstale_a,
   input  logic                    ren_b,
   input  logic [ADDR_W-1:0]       raddr_b,
   output logic [WIDTH-1:0]        rdata_b,
   output logic                    rvalid_b,
   output logic                    rstale_b,
   input  logic                    issue,
   input  logic [ADDR_W-1:0]       issue_sel,
   output logic [(2**ADDR_W)-1:0]  busy,
   input  logic [ADDR_W-1:0]       dbg_sel,
   output logic [WIDTH-1:0]        dbg_q
);

   localparam int NREGS = 2**ADDR_W;

`ifdef ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   logic [WIDTH-1:0] regs [NREGS];
   logic [NREGS-1:0] busy_nxt;
   logic             wr_eff;
   logic             iss_eff;
   logic [WIDTH-1:0] rd_val_a;
   logic [WIDTH-1:0] rd_val_b;
   logic             stale_a;
   logic             stale_b;

   // With the zero register, writes and issues aimed at register 0 are dropped.
   assign wr_eff  = wen   & ~(ZERO_REG & (waddr == '0));
   assign iss_eff = issue & ~(ZERO_REG & (issue_sel == '0));

   // A write landing this edge retires the pending result, so it is not stale.
   assign stale_a = busy[raddr_a] & ~(wen & (waddr == raddr_a));
   assign stale_b = busy[raddr_b] & ~(wen & (waddr == raddr_b));

   always_comb begin
      rd_val_a = regs[raddr_a];
      if (ZERO_REG && (raddr_a == '0)) begin
         rd_val_a = '0;
      end else if (wr_eff && (waddr == raddr_a)) begin
         rd_val_a = wdata;
      end
   end

   always_comb begin
      rd_val_b = regs[raddr_b];
      if (ZERO_REG && (raddr_b == '0)) begin
         rd_val_b = '0;
      end else if (wr_eff && (waddr == raddr_b)) begin
         rd_val_b = wdata;
      end
   end

   // Clear on write first, then set on issue: a new producer issued in the same
   // cycle as the old result retires keeps the register busy.
   always_comb begin
      busy_nxt = busy;
      if (wr_eff) begin
         busy_nxt[waddr] = 1'b0;
      end
      if (iss_eff) begin
         busy_nxt[issue_sel] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VAL;
         end
         busy     <= '0;
         rdata_a  <= '0;
         rvalid_a <= 1'b0;
         rstale_a <= 1'b0;
         rdata_b  <= '0;
         rvalid_b <= 1'b0;
         rstale_b <= 1'b0;
      end else begin
         if (wr_eff) begin
            regs[waddr] <= wdata;
         end
         busy <= busy_nxt;

         // rdata holds its last value when no read is requested.
         if (ren_a) begin
            rdata_a  <= rd_val_a;
            rvalid_a <= 1'b1;
            rstale_a <= stale_a;
         end else begin
            rvalid_a <= 1'b0;
            rstale_a <= 1'b0;
         end

         if (ren_b) begin
            rdata_b  <= rd_val_b;
            rvalid_b <= 1'b1;
            rstale_b <= stale_b;
         end else begin
            rvalid_b <= 1'b0;
            rstale_b <= 1'b0;
         end
      end
   end

   assign dbg_q = (ZERO_REG && (dbg_sel == '0)) ? '0 : regs[dbg_sel];

endmodule
